// File: rtl/snn_pkg.sv
// Shared constants for the spike-encoding front end: FSM encoding, default sizing, LFSR seed.
// Imported by the sequencer, its counters and the bench encoder model.
package snn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int          DEF_T_STEPS = 64;
  localparam int          DEF_CNT_W   = 8;
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: clears on reset or clear and increments on inc.
// Latency: one cycle. Holds at all-ones instead of wrapping.
module sat_counter import snn_pkg::*; #(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spike_present_ctrl.sv
// Presents one RGB pixel to the spike encoder for T_STEPS timesteps and forwards spikes.
// Per-channel spike counts are accumulated and handed off over valid/ready.
module spike_present_ctrl import snn_pkg::*; #(
  parameter int T_STEPS = DEF_T_STEPS,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int ENC_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [7:0]       pix_r,
  input  logic [7:0]       pix_g,
  input  logic [7:0]       pix_b,
  output logic             enc_reset,
  output logic [7:0]       r_st,
  output logic [7:0]       g_st,
  output logic [7:0]       b_st,
  input  logic             r_sp,
  input  logic             g_sp,
  input  logic             b_sp,
  output logic             spk_valid,
  output logic             spk_r,
  output logic             spk_g,
  output logic             spk_b,
  output logic [15:0]      step_idx,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [CNT_W-1:0] r_cnt,
  output logic [CNT_W-1:0] g_cnt,
  output logic [CNT_W-1:0] b_cnt
);

  state_t             state, state_nxt;
  logic [15:0]        cnt, cnt_nxt;
  logic [ENC_LAT-1:0] vld_sr;
  logic [15:0]        step_pipe [ENC_LAT];
  logic               accept;
  logic               handoff;
  logic               cap;

  assign pix_ready  = (state == ST_IDLE);
  assign enc_reset  = (state == ST_SEED);
  assign busy       = (state != ST_IDLE);
  assign done_valid = (state == ST_DONE);
  assign accept     = pix_valid && pix_ready;
  assign handoff    = done_valid && done_ready;

  // The oldest shift-register bit marks the cycle whose encoder spikes are valid.
  assign cap       = vld_sr[ENC_LAT-1];
  assign spk_valid = cap;
  assign spk_r     = cap && r_sp;
  assign spk_g     = cap && g_sp;
  assign spk_b     = cap && b_sp;
  assign step_idx  = step_pipe[ENC_LAT-1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (accept) state_nxt = ST_SEED;
      end
      ST_SEED: begin
        cnt_nxt   = '0;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (cnt == 16'(T_STEPS - 1)) begin
          cnt_nxt   = '0;
          state_nxt = ST_DRAIN;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      // The same counter times the drain so in-flight encoder results are not lost.
      ST_DRAIN: begin
        if (cnt == 16'(ENC_LAT - 1)) begin
          cnt_nxt   = '0;
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      ST_DONE: begin
        if (done_ready) state_nxt = ST_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      vld_sr <= '0;
      r_st   <= '0;
      g_st   <= '0;
      b_st   <= '0;
      for (int i = 0; i < ENC_LAT; i++) step_pipe[i] <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      vld_sr[0]    <= (state == ST_RUN);
      step_pipe[0] <= cnt;
      for (int i = 1; i < ENC_LAT; i++) begin
        vld_sr[i]    <= vld_sr[i-1];
        step_pipe[i] <= step_pipe[i-1];
      end
      if (accept) begin
        r_st <= pix_r;
        g_st <= pix_g;
        b_st <= pix_b;
      end else if (handoff) begin
        r_st <= '0;
        g_st <= '0;
        b_st <= '0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_r (
    .clk(clk), .reset(reset), .clear(accept), .inc(cap && r_sp), .cnt(r_cnt)
  );

  sat_counter #(.W(CNT_W)) u_cnt_g (
    .clk(clk), .reset(reset), .clear(accept), .inc(cap && g_sp), .cnt(g_cnt)
  );

  sat_counter #(.W(CNT_W)) u_cnt_b (
    .clk(clk), .reset(reset), .clear(accept), .inc(cap && b_sp), .cnt(b_cnt)
  );

endmodule
